boton_antirebote: RTL
=====================

BOTON_ANTIREBOTE -- requirements
Module: boton_antirebote

Interface
REQ-001 Parameter: CICLOS_ESTABLE, default 1_000_000, number of consecutive clock cycles the synchronized button must hold a level before it is accepted; legal range is 2 or more.
REQ-002 Port: clk  input  1  system clock; all logic is on the rising edge.
REQ-003 Port: reset_i  input  1  asynchronous, active-high reset.
REQ-004 Port: boton_i  input  1  raw mechanical button, asynchronous to clk and subject to bounce.
REQ-005 Port: pulso_o  output  1  single-cycle strobe on each accepted press; this is the counter's increment input.
REQ-006 Port: nivel_o  output  1  debounced button level; 1 means pressed.

Function
REQ-007 boton_i SHALL pass through a 2-flop synchronizer; the output of the second flop is "s", and the FSM uses only s.
REQ-008 The FSM SHALL have 4 states: REPOSO, FILTRO_ON, PRESIONADO, FILTRO_OFF.
REQ-009 REPOSO: if s=1, go to FILTRO_ON with cnt cleared to 0; otherwise stay.
REQ-010 FILTRO_ON handles a rising candidate:
- if s=0, return to REPOSO and clear cnt;
- else if cnt = CICLOS_ESTABLE-1, go to PRESIONADO;
- else increment cnt.
REQ-011 PRESIONADO: if s=0, go to FILTRO_OFF with cnt cleared to 0; otherwise stay. Holding the button indefinitely SHALL NOT produce further pulses.
REQ-012 FILTRO_OFF mirrors FILTRO_ON with levels swapped:
- if s=1, return to PRESIONADO;
- at cnt = CICLOS_ESTABLE-1, go to REPOSO.
REQ-013 cnt width SHALL be ceil(log2(CICLOS_ESTABLE)) bits; cnt never exceeds CICLOS_ESTABLE-1 and never wraps.
REQ-014 pulso_o SHALL be registered and high for exactly the one cycle following the FILTRO_ON->PRESIONADO transition. No other transition asserts it.
REQ-015 Latency: take edge 0 as the first edge that samples boton_i=1 on a stable press. pulso_o SHALL be high in the cycle following edge CICLOS_ESTABLE+2.
REQ-016 nivel_o SHALL be registered and equal 1 exactly while the state is PRESIONADO or FILTRO_OFF. It therefore rises together with pulso_o and falls CICLOS_ESTABLE+2 edges after the release is first sampled.
REQ-017 Bounces shorter than CICLOS_ESTABLE cycles SHALL produce no change on pulso_o or nivel_o. Each interruption restarts the filter from cnt=0.

Reset
REQ-018 While reset_i=1, regardless of clk, the following SHALL hold:
- both synchronizer flops = 0;
- state = REPOSO;
- cnt = 0;
- pulso_o = 0;
- nivel_o = 0.
REQ-019 Reset asserted mid-filter SHALL abandon the filter. If the button is still held after reset deasserts, one full new filter SHALL run and yield exactly one pulse.
REQ-020 Reset deassertion is taken synchronously by the downstream logic. No pulse SHALL be generated within the first 2 cycles after deassertion.

Structure
REQ-021 A shared package SHALL hold:
- the state enum type with its 4 values;
- the CICLOS_ESTABLE default constant.
REQ-022 The synchronizer SHALL be the sub-module sincronizador: 1 bit wide, 2 flops, using the same clk and reset_i. The FSM, counter and output registers SHALL live in boton_antirebote.
REQ-023 The block SHALL contain no latches and no combinational path from boton_i to any output.

Verification
All scenarios run with CICLOS_ESTABLE=4 and a 10 ns clock.
REQ-024 Reset: assert reset_i with boton_i=1 -> pulso_o=0 and nivel_o=0 immediately and throughout reset.
REQ-025 Clean press: hold boton_i=1 for 20 cycles (edge 0 = first sample), then release.
- exactly one pulso_o, high after edge 6;
- nivel_o high after edge 6;
- nivel_o low 6 edges after the release is first sampled;
- no pulse on release.
REQ-026 Bounce: drive boton_i as 1,1,0,1,1,0 then steady 1 -> exactly one pulse, 6 edges after the final rising sample; no activity before it.
REQ-027 Glitch: drive boton_i=1 for 3 cycles, then 0 -> pulso_o and nivel_o stay 0 throughout.
REQ-028 Reset mid-filter: assert reset_i for 1 cycle while in FILTRO_ON with the button held -> outputs 0; after deassertion exactly one pulse, 6 edges after the first post-reset sample.
REQ-029 Repeat: do 5 clean presses, each 10 cycles high and 10 low -> exactly 5 pulses, and a downstream 8-bit counter reads 8'h05.

Source files
------------

// File: rtl/boton_antirebote_pkg.sv
// Shared types and constants for the button debouncer.
package boton_antirebote_pkg;

    typedef enum logic [1:0] {
        REPOSO,
        FILTRO_ON,
        PRESIONADO,
        FILTRO_OFF
    } estado_t;

    localparam int unsigned CICLOS_ESTABLE_DEF = 1_000_000;

endpackage

// File: rtl/boton_antirebote_if.sv
// Button-side signal bundle: raw button in, debounced strobe and level out.
interface boton_antirebote_if;

    logic boton;
    logic pulso;
    logic nivel;

    modport master (output boton, input pulso, input nivel);
    modport slave (input boton, output pulso, output nivel);

endinterface

// File: rtl/boton_antirebote_sincronizador.sv
// Two-flop synchronizer bringing the asynchronous button into the clk domain.
module sincronizador (
    input  logic clk,
    input  logic reset_i,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/boton_antirebote.sv
// Debounces a mechanical button: a level is accepted only after holding for
// CICLOS_ESTABLE cycles; each accepted press emits a one-cycle strobe.
module boton_antirebote
    import boton_antirebote_pkg::*;
#(
    parameter int unsigned CICLOS_ESTABLE = CICLOS_ESTABLE_DEF
) (
    input  logic clk,
    input  logic reset_i,
    input  logic boton_i,
    output logic pulso_o,
    output logic nivel_o
);

    localparam int unsigned CNT_W = $clog2(CICLOS_ESTABLE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CICLOS_ESTABLE - 1);

    logic             s;
    estado_t          estado, estado_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             pulso_next;
    logic             nivel_next;

    sincronizador u_sincronizador (
        .clk     (clk),
        .reset_i (reset_i),
        .d       (boton_i),
        .q       (s)
    );

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            estado  <= REPOSO;
            cnt     <= '0;
            pulso_o <= 1'b0;
            nivel_o <= 1'b0;
        end else begin
            estado  <= estado_next;
            cnt     <= cnt_next;
            pulso_o <= pulso_next;
            nivel_o <= nivel_next;
        end
    end

    always_comb begin
        estado_next = estado;
        cnt_next    = cnt;
        pulso_next  = 1'b0;
        case (estado)
            REPOSO: begin
                if (s) begin
                    estado_next = FILTRO_ON;
                    cnt_next    = '0;
                end
            end
            FILTRO_ON: begin
                if (!s) begin
                    estado_next = REPOSO;
                    cnt_next    = '0;
                end else if (cnt == CNT_MAX) begin
                    estado_next = PRESIONADO;
                    cnt_next    = '0;
                    pulso_next  = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            PRESIONADO: begin
                if (!s) begin
                    estado_next = FILTRO_OFF;
                    cnt_next    = '0;
                end
            end
            FILTRO_OFF: begin
                if (s) begin
                    estado_next = PRESIONADO;
                    cnt_next    = '0;
                end else if (cnt == CNT_MAX) begin
                    estado_next = REPOSO;
                    cnt_next    = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                estado_next = REPOSO;
                cnt_next    = '0;
            end
        endcase
        // Level is registered from the next state so it rises together with the strobe.
        nivel_next = (estado_next == PRESIONADO) || (estado_next == FILTRO_OFF);
    end

endmodule
